// File: rtl/weights_sa_feeder.sv
// Double-buffered feeder that streams a captured ROWSxCOLS weight vector into the systolic array row by row.
// Optional checksum outputs are enabled by defining WFEED_CHKSUM_EN.
module weights_sa_feeder #(
    parameter int unsigned ROWS  = 9,
    parameter int unsigned COLS  = 32,
    parameter int unsigned IDX_W = 4
) (
    input  logic                           i_clk,
    input  logic                           i_rstn,
    input  logic                           i_load,
    input  logic signed [ROWS*COLS*8-1:0]  i_weights,
    output logic                           o_load_ready,
    output logic [COLS*8-1:0]              o_row_data,
    output logic [IDX_W-1:0]               o_row_idx,
    output logic                           o_row_valid,
    input  logic                           i_sa_ready,
    output logic                           o_busy,
    output logic                           o_done
`ifdef WFEED_CHKSUM_EN
    ,
    output logic signed [15:0]             o_chksum,
    output logic                           o_chksum_valid
`endif
);

    localparam int unsigned ROW_W = COLS * 8;
    localparam int unsigned VEC_W = ROWS * ROW_W;

    typedef enum logic {
        IDLE,
        STREAM
    } state_e;

    state_e             state_q, state_d;
    logic [VEC_W-1:0]   active_q, active_d;
    logic [VEC_W-1:0]   pend_q, pend_d;
    logic               pend_full_q, pend_full_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               done_q, done_d;

    logic               load_acc;
    logic               beat;
    logic               last_beat;
    logic [ROW_W-1:0]   cur_row;

    assign cur_row      = active_q[ROW_W * 32'(idx_q) +: ROW_W];
    assign o_load_ready = !pend_full_q;
    assign o_row_valid  = (state_q == STREAM);
    assign o_busy       = (state_q == STREAM);
    assign o_row_idx    = idx_q;
    assign o_row_data   = o_row_valid ? cur_row : '0;
    assign o_done       = done_q;

    assign load_acc  = i_load && o_load_ready;
    assign beat      = o_row_valid && i_sa_ready;
    assign last_beat = beat && (idx_q == IDX_W'(ROWS - 1));

    always_comb begin
        state_d     = state_q;
        active_d    = active_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        idx_d       = idx_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_acc) begin
                    active_d = i_weights;
                    idx_d    = '0;
                    state_d  = STREAM;
                end
            end
            STREAM: begin
                if (last_beat) begin
                    done_d = 1'b1;
                    idx_d  = '0;
                    // Pending vector wins; a same-cycle load can only arrive when pending is empty.
                    if (pend_full_q) begin
                        active_d    = pend_q;
                        pend_full_d = 1'b0;
                    end else if (load_acc) begin
                        active_d = i_weights;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (beat) begin
                        idx_d = idx_q + 1'b1;
                    end
                    if (load_acc) begin
                        pend_d      = i_weights;
                        pend_full_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q     <= IDLE;
            active_q    <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            idx_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            active_q    <= active_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            idx_q       <= idx_d;
            done_q      <= done_d;
        end
    end

`ifdef WFEED_CHKSUM_EN
    logic signed [15:0] acc_q, acc_d;
    logic signed [15:0] chksum_q, chksum_d;
    logic               chkv_q, chkv_d;
    logic signed [15:0] row_sum;

    always_comb begin
        row_sum = '0;
        for (int unsigned c = 0; c < COLS; c++) begin
            row_sum = row_sum + {{8{cur_row[8*c+7]}}, cur_row[8*c +: 8]};
        end
    end

    // Accumulator restarts at zero on the last beat so the next vector begins clean.
    always_comb begin
        acc_d    = acc_q;
        chksum_d = chksum_q;
        chkv_d   = 1'b0;
        if (last_beat) begin
            acc_d    = '0;
            chksum_d = acc_q + row_sum;
            chkv_d   = 1'b1;
        end else if (beat) begin
            acc_d = acc_q + row_sum;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            acc_q    <= '0;
            chksum_q <= '0;
            chkv_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            chksum_q <= chksum_d;
            chkv_q   <= chkv_d;
        end
    end

    assign o_chksum       = chksum_q;
    assign o_chksum_valid = chkv_q;
`endif

endmodule

// File: tb/tb_weights_sa_feeder.sv
// Directed self-checking bench for weights_sa_feeder; checksum checks compile in with WFEED_CHKSUM_EN.
module tb_weights_sa_feeder;

    localparam int ROWS  = 9;
    localparam int COLS  = 32;
    localparam int IDX_W = 4;
    localparam int RW    = COLS * 8;
    localparam int N     = ROWS * RW;

    logic                  i_clk = 1'b0;
    logic                  i_rstn;
    logic                  i_load;
    logic signed [N-1:0]   i_weights;
    logic                  o_load_ready;
    logic [RW-1:0]         o_row_data;
    logic [IDX_W-1:0]      o_row_idx;
    logic                  o_row_valid;
    logic                  i_sa_ready;
    logic                  o_busy;
    logic                  o_done;
`ifdef WFEED_CHKSUM_EN
    logic signed [15:0]    o_chksum;
    logic                  o_chksum_valid;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    logic [N-1:0] va, vb, vc, vm, vo;

    always #5 i_clk = ~i_clk;

    weights_sa_feeder #(
        .ROWS  (ROWS),
        .COLS  (COLS),
        .IDX_W (IDX_W)
    ) dut (
        .i_clk        (i_clk),
        .i_rstn       (i_rstn),
        .i_load       (i_load),
        .i_weights    (i_weights),
        .o_load_ready (o_load_ready),
        .o_row_data   (o_row_data),
        .o_row_idx    (o_row_idx),
        .o_row_valid  (o_row_valid),
        .i_sa_ready   (i_sa_ready),
        .o_busy       (o_busy),
        .o_done       (o_done)
`ifdef WFEED_CHKSUM_EN
        ,
        .o_chksum       (o_chksum),
        .o_chksum_valid (o_chksum_valid)
`endif
    );

    always @(posedge i_clk) begin
        if (o_done) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load_idle(input logic [N-1:0] vec);
        i_load    = 1'b1;
        i_weights = vec;
        @(negedge i_clk);
        i_load    = 1'b0;
    endtask

    // Walks rows start_row..stop_row of vec, checking each shown row; optional stall and mid-stream loads.
    task automatic expect_vector(input logic [N-1:0] vec, input int start_row, input int stop_row,
                                 input int stall_row, input int stall_n,
                                 input int load_row, input logic [N-1:0] load_vec,
                                 input int load2_row, input logic [N-1:0] load2_vec);
        for (int r = start_row; r < ROWS; r++) begin
            i_load = 1'b0;
            check("row_valid", RW'(o_row_valid), RW'(1));
            check("row_idx", RW'(o_row_idx), RW'(r));
            check("row_data", o_row_data, vec[r*RW +: RW]);
            check("busy", RW'(o_busy), RW'(1));
            if (load_row >= 0 && r == load_row + 1) check("load_ready_low", RW'(o_load_ready), RW'(0));
            if (r == load_row) begin
                check("load_ready_high", RW'(o_load_ready), RW'(1));
                i_load    = 1'b1;
                i_weights = load_vec;
            end
            if (r == load2_row) begin
                i_load    = 1'b1;
                i_weights = load2_vec;
            end
            if (r == stop_row) return;
            if (r == stall_row) begin
                i_sa_ready = 1'b0;
                repeat (stall_n) begin
                    @(negedge i_clk);
                    i_load = 1'b0;
                    check("stall_valid", RW'(o_row_valid), RW'(1));
                    check("stall_idx", RW'(o_row_idx), RW'(r));
                    check("stall_data", o_row_data, vec[r*RW +: RW]);
                end
                i_sa_ready = 1'b1;
            end
            @(negedge i_clk);
        end
        i_load = 1'b0;
    endtask

    task automatic check_idle_after_done();
        check("done_pulse", RW'(o_done), RW'(1));
        check("idle_valid", RW'(o_row_valid), RW'(0));
        check("idle_busy", RW'(o_busy), RW'(0));
        check("idle_idx", RW'(o_row_idx), RW'(0));
        @(negedge i_clk);
        check("done_low", RW'(o_done), RW'(0));
    endtask

    initial begin
        int d0;
        for (int k = 0; k < ROWS * COLS; k++) begin
            va[8*k +: 8] = 8'(k % 128);
            vb[8*k +: 8] = 8'hFF;
            vc[8*k +: 8] = 8'((k * 3 + 7) % 256);
            vm[8*k +: 8] = 8'h80;
            vo[8*k +: 8] = 8'h01;
        end
        i_rstn     = 1'b0;
        i_load     = 1'b0;
        i_weights  = '0;
        i_sa_ready = 1'b1;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        check("rst_valid", RW'(o_row_valid), RW'(0));
        check("rst_idx", RW'(o_row_idx), RW'(0));
        check("rst_data", o_row_data, '0);
        check("rst_busy", RW'(o_busy), RW'(0));
        check("rst_done", RW'(o_done), RW'(0));
        check("rst_load_ready", RW'(o_load_ready), RW'(1));
`ifdef WFEED_CHKSUM_EN
        check("rst_chksum", RW'(o_chksum), RW'(0));
        check("rst_chksum_valid", RW'(o_chksum_valid), RW'(0));
`endif
        i_rstn = 1'b1;
        @(negedge i_clk);

        // Basic stream, with hand-computed row 2 lane 5 = 2*32+5 = 69.
        load_idle(va);
        expect_vector(va, 0, 2, -1, 0, -1, '0, -1, '0);
        check("r2_lane5", RW'(o_row_data[47:40]), RW'(69));
        @(negedge i_clk);
        expect_vector(va, 3, ROWS, -1, 0, -1, '0, -1, '0);
        check_idle_after_done();

        // Backpressure on row 4 for three cycles.
        load_idle(vc);
        expect_vector(vc, 0, ROWS, 4, 3, -1, '0, -1, '0);
        check_idle_after_done();

        // A then pending B (all -1); third load C while B pending is dropped.
        d0 = done_cnt;
        load_idle(va);
        expect_vector(va, 0, ROWS, -1, 0, 3, vb, 5, vc);
        check("ab_done", RW'(o_done), RW'(1));
        check("b_row0_lane0", RW'(o_row_data[7:0]), RW'(8'hFF));
        expect_vector(vb, 0, ROWS, -1, 0, -1, '0, -1, '0);
        check_idle_after_done();
        @(negedge i_clk);
        check("c_dropped_valid", RW'(o_row_valid), RW'(0));
        check("two_dones", RW'(done_cnt - d0), RW'(2));

        // Reset at row 5 with B pending discards everything.
        load_idle(va);
        expect_vector(va, 0, 5, -1, 0, 1, vb, -1, '0);
        i_load = 1'b0;
        i_rstn = 1'b0;
        @(negedge i_clk);
        check("mrst_valid", RW'(o_row_valid), RW'(0));
        check("mrst_idx", RW'(o_row_idx), RW'(0));
        check("mrst_data", o_row_data, '0);
        check("mrst_busy", RW'(o_busy), RW'(0));
        check("mrst_done", RW'(o_done), RW'(0));
        check("mrst_load_ready", RW'(o_load_ready), RW'(1));
        i_rstn = 1'b1;
        @(negedge i_clk);
        check("mrst_no_pending", RW'(o_row_valid), RW'(0));
        load_idle(vc);
        expect_vector(vc, 0, ROWS, -1, 0, -1, '0, -1, '0);
        check_idle_after_done();

`ifdef WFEED_CHKSUM_EN
        load_idle(vm);
        expect_vector(vm, 0, ROWS, -1, 0, -1, '0, -1, '0);
        check("chk_neg_valid", RW'(o_chksum_valid), RW'(1));
        check("chk_neg_value", RW'(o_chksum), RW'(16'h7000));
        check_idle_after_done();
        check("chk_valid_low", RW'(o_chksum_valid), RW'(0));
        load_idle(vo);
        expect_vector(vo, 0, ROWS, -1, 0, -1, '0, -1, '0);
        check("chk_one_valid", RW'(o_chksum_valid), RW'(1));
        check("chk_one_value", RW'(o_chksum), RW'(288));
        check_idle_after_done();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
